// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and helpers for the serial pattern detector
package seq_det_pkg;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_CNT_W   = 16;

  // Widest compare mask the helper can build; callers truncate to MAX_LEN.
  localparam int MASK_W = 32;

  function automatic logic [MASK_W-1:0] len_mask(input logic [MASK_W-1:0] len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      m[i] = (MASK_W'(i) < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear priority
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-configurable serial bit-pattern detector
// with Mealy match, registered match and saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clear,
  input  logic               x_valid,
  input  logic               x,
  output logic               match,
  output logic               match_q,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pat_q,  pat_d;
  logic [LEN_W-1:0]   len_q,  len_d;
  logic               ovl_q,  ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_inc;
  logic               accept;
  logic               enough_bits;
  logic               window_hit;

  // The shifted history doubles as the candidate window: newest bit at 0.
  assign window      = MAX_LEN'({hist_q, x});
  assign mask        = MAX_LEN'(len_mask(MASK_W'(len_q)));
  assign fill_inc    = {1'b0, fill_q} + (LEN_W+1)'(1);
  assign accept      = x_valid && !cfg_load;
  assign enough_bits = (fill_inc >= {1'b0, len_q});
  assign window_hit  = (((window ^ pat_q) & mask) == '0);
  assign match       = accept && (len_q != '0) && enough_bits && window_hit;

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (x_valid) begin
      hist_d = window;
      // Non-overlapping: a match restarts the search from the next bit.
      if (match && (ovl_q == OVL_OFF)) begin
        fill_d = '0;
      end else if (fill_q != MAX_LEN_L) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= OVL_OFF;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clear),
    .inc  (match),
    .q    (match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed table-driven bench for seq_detector_param
module tb_seq_detector_param;

  logic        clk;
  logic        reset;
  logic        cfg_load;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic        cnt_clear;
  logic        x_valid;
  logic        x;
  logic        match;
  logic        match_q;
  logic [15:0] match_count;
  logic        match2;
  logic        match_q2;
  logic [1:0]  match_count2;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        ld;
    logic [7:0]  pat;
    logic [3:0]  len;
    logic        ovl;
    logic        clr;
    logic        v;
    logic        xb;
    logic        em;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[$];

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear),
    .x_valid(x_valid), .x(x), .match(match), .match_q(match_q),
    .match_count(match_count)
  );

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear),
    .x_valid(x_valid), .x(x), .match(match2), .match_q(match_q2),
    .match_count(match_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic ld_row(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    vec_t r;
    r = '{ld: 1'b1, pat: pat, len: len, ovl: ovl, clr: 1'b1, v: 1'b0, xb: 1'b0,
          em: 1'b0, ec: 16'd0};
    tbl.push_back(r);
  endtask

  task automatic bit_row(input logic v, input logic xb, input logic em, input logic [15:0] ec);
    vec_t r;
    r = '{ld: 1'b0, pat: 8'h00, len: 4'd0, ovl: 1'b0, clr: 1'b0, v: v, xb: xb,
          em: em, ec: ec};
    tbl.push_back(r);
  endtask

  task automatic drive(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                       input logic ovl, input logic clr, input logic v, input logic xb);
    @(negedge clk);
    cfg_load    = ld;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cnt_clear   = clr;
    x_valid     = v;
    x           = xb;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    cfg_load = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    cnt_clear = 1'b0; x_valid = 1'b1; x = 1'b1;

    // Reset state, with a valid bit presented during reset.
    after_edge();
    after_edge();
    chk("reset match", {31'd0, match}, 32'd0);
    chk("reset match_q", {31'd0, match_q}, 32'd0);
    chk("reset count", {16'd0, match_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle();

    // 1011 non-overlapping: only bit 4 matches.
    ld_row(8'h0B, 4'd4, 1'b0);
    bit_row(1, 1, 0, 0); bit_row(1, 0, 0, 0); bit_row(1, 1, 0, 0); bit_row(1, 1, 1, 1);
    bit_row(1, 0, 0, 1); bit_row(1, 1, 0, 1); bit_row(1, 1, 0, 1);
    // 1011 overlapping: bits 4 and 7.
    ld_row(8'h0B, 4'd4, 1'b1);
    bit_row(1, 1, 0, 0); bit_row(1, 0, 0, 0); bit_row(1, 1, 0, 0); bit_row(1, 1, 1, 1);
    bit_row(1, 0, 0, 1); bit_row(1, 1, 0, 1); bit_row(1, 1, 1, 2);
    // 1010 overlapping: bits 4 and 6.
    ld_row(8'h0A, 4'd4, 1'b1);
    bit_row(1, 1, 0, 0); bit_row(1, 0, 0, 0); bit_row(1, 1, 0, 0); bit_row(1, 0, 1, 1);
    bit_row(1, 1, 0, 1); bit_row(1, 0, 1, 2);
    // 1010 non-overlapping: bit 4 only.
    ld_row(8'h0A, 4'd4, 1'b0);
    bit_row(1, 1, 0, 0); bit_row(1, 0, 0, 0); bit_row(1, 1, 0, 0); bit_row(1, 0, 1, 1);
    bit_row(1, 1, 0, 1); bit_row(1, 0, 0, 1);
    // len 1, pattern 1, gaps (x high but not valid) are transparent.
    ld_row(8'h01, 4'd1, 1'b0);
    bit_row(1, 1, 1, 1); bit_row(0, 1, 0, 1); bit_row(1, 1, 1, 2); bit_row(0, 1, 0, 2);
    bit_row(0, 0, 0, 2); bit_row(1, 1, 1, 3);
    // len 0 disables detection.
    ld_row(8'h00, 4'd0, 1'b1);
    bit_row(1, 0, 0, 0); bit_row(1, 0, 0, 0); bit_row(1, 1, 0, 0); bit_row(1, 1, 0, 0);
    // len 15 clamps to 8: 10100101 matches only on the eighth bit.
    ld_row(8'hA5, 4'd15, 1'b1);
    bit_row(1, 1, 0, 0); bit_row(1, 0, 0, 0); bit_row(1, 1, 0, 0); bit_row(1, 0, 0, 0);
    bit_row(1, 0, 0, 0); bit_row(1, 1, 0, 0); bit_row(1, 0, 0, 0); bit_row(1, 1, 1, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].clr, tbl[i].v, tbl[i].xb);
      chk($sformatf("row%0d match", i), {31'd0, match}, {31'd0, tbl[i].em});
      after_edge();
      chk($sformatf("row%0d match_q", i), {31'd0, match_q}, {31'd0, tbl[i].em});
      chk($sformatf("row%0d count", i), {16'd0, match_count}, {16'd0, tbl[i].ec});
    end
    idle();

    // cfg_load together with x_valid drops the bit; 1,0,1,1 then completes later.
    drive(1'b1, 8'h0B, 4'd4, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("load+valid match", {31'd0, match}, 32'd0);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("dropped bit not used", {31'd0, match}, 32'd0);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("post-drop match", {31'd0, match}, 32'd1);
    after_edge();
    chk("post-drop count", {16'd0, match_count}, 32'd1);
    idle();

    // Reset mid-pattern.
    drive(1'b1, 8'h0B, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    #1;
    chk("midreset match", {31'd0, match}, 32'd0);
    chk("midreset match_q", {31'd0, match_q}, 32'd0);
    chk("midreset count", {16'd0, match_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("no reload no match", {31'd0, match}, 32'd0);
    drive(1'b1, 8'h0B, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("reload lone 1", {31'd0, match}, 32'd0);
    after_edge();
    chk("reload lone 1 count", {16'd0, match_count}, 32'd0);

    // 2-bit counter saturation and clear-over-match priority.
    drive(1'b1, 8'h01, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    after_edge();
    chk("cnt2 cleared", {30'd0, match_count2}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("cnt2 match%0d", k), {31'd0, match2}, 32'd1);
      after_edge();
      chk($sformatf("cnt2 step%0d", k), {30'd0, match_count2}, (k > 3) ? 32'd3 : 32'(k));
    end
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr+match match", {31'd0, match2}, 32'd1);
    after_edge();
    chk("clr+match cnt2", {30'd0, match_count2}, 32'd0);
    chk("clr+match cnt16", {16'd0, match_count}, 32'd0);
    chk("clr+match match_q", {31'd0, match_q2}, 32'd1);
    idle();
    after_edge();
    chk("idle match_q", {31'd0, match_q2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
